// File: rtl/cpu_pkg.sv
// Shared constants for the 24-bit CPU front end.
//   DATA_W / ADDR_W : instruction word and address widths
//   RESET_PC        : default PC loaded on reset
//   S_*             : 2-bit encoding of the fetch FSM states
package cpu_pkg;

  localparam int DATA_W = 24;
  localparam int ADDR_W = 24;

  localparam logic [ADDR_W-1:0] RESET_PC = 24'h000000;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t S_IDLE  = 2'd0;
  localparam fetch_state_t S_REQ   = 2'd1;
  localparam fetch_state_t S_HOLD  = 2'd2;
  localparam fetch_state_t S_DRAIN = 2'd3;

endpackage

// File: rtl/fetch_unit_pc_next_sel.sv
// Next-PC select: PC+1 (modulo 2^ADDR_W) or RedirectPC, built from one
// mux2ne1 cell per address bit.
//   PC         : current program counter
//   RedirectPC : branch/jump target
//   Redirect   : selects RedirectPC when 1
//   NextPC     : selected next program counter
import cpu_pkg::*;

module pc_next_sel #(
  parameter int AW = ADDR_W
) (
  input  logic [AW-1:0] PC,
  input  logic [AW-1:0] RedirectPC,
  input  logic          Redirect,
  output logic [AW-1:0] NextPC
);

  logic [AW-1:0] pc_inc;

  // Width-matched add drops the carry, so all-ones wraps to zero.
  assign pc_inc = PC + {{(AW-1){1'b0}}, 1'b1};

  // The cell passes Hyrja0 when S=1, hence the target goes on Hyrja0.
  for (genvar i = 0; i < AW; i++) begin : g_bit
    mux2ne1 u_mux (
      .Hyrja0 (RedirectPC[i]),
      .Hyrja1 (pc_inc[i]),
      .S      (Redirect),
      .Dalja  (NextPC[i])
    );
  end

endmodule

// File: rtl/mux2ne1.sv
// Single-bit 2:1 mux cell.
//   Hyrja0 : passed through when S=1
//   Hyrja1 : passed through when S=0
//   S      : select
//   Dalja  : output
module mux2ne1 (
  input  logic Hyrja0,
  input  logic Hyrja1,
  input  logic S,
  output logic Dalja
);

  assign Dalja = S ? Hyrja0 : Hyrja1;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches one word per req/ack
// transaction and presents {Instr, InstrPC} to decode.
//   Clock, Reset_n          : rising-edge clock, async active-low reset
//   Redirect, RedirectPC    : branch/jump redirect from execute
//   ImemReq/ImemAddr        : fetch request, held with a stable address until ImemAck
//   ImemAck/ImemData        : one-cycle ack with the word valid in the same cycle
//   InstrValid/InstrReady   : decode handshake
//   Instr/InstrPC           : registered instruction and its address
//   DbgState                : current FSM state (cpu_pkg S_* encoding)
//
// Handshakes: a transfer happens on a rising edge where the producer's
// valid (ImemReq / InstrValid) and the consumer's ready (ImemAck /
// InstrReady) are both 1; the producer keeps its payload stable until then.
import cpu_pkg::*;

module fetch_unit #(
  parameter int                DW  = DATA_W,
  parameter int                AW  = ADDR_W,
  parameter logic [ADDR_W-1:0] RPC = RESET_PC
) (
  input  logic          Clock,
  input  logic          Reset_n,
  input  logic          Redirect,
  input  logic [AW-1:0] RedirectPC,
  output logic          ImemReq,
  output logic [AW-1:0] ImemAddr,
  input  logic          ImemAck,
  input  logic [DW-1:0] ImemData,
  output logic          InstrValid,
  input  logic          InstrReady,
  output logic [DW-1:0] Instr,
  output logic [AW-1:0] InstrPC,
  output fetch_state_t  DbgState
);

  fetch_state_t  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] drain_q, drain_d;
  logic [DW-1:0] instr_q, instr_d;
  logic [AW-1:0] instr_pc_q, instr_pc_d;
  logic          valid_q, valid_d;
  logic [AW-1:0] next_pc;
  logic          redir_act;
  logic          fetch_done;

  pc_next_sel #(.AW(AW)) u_pc_next_sel (
    .PC         (pc_q),
    .RedirectPC (RedirectPC),
    .Redirect   (Redirect),
    .NextPC     (next_pc)
  );

  // Redirect is ignored in IDLE only.
  assign redir_act  = Redirect && (state_q != S_IDLE);
  // A fetch that decode will see: acked in REQ and not killed by a redirect.
  assign fetch_done = (state_q == S_REQ) && ImemAck && !Redirect;

  // FSM: state register
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (Redirect) begin
          // Without an ack the outstanding request must still finish.
          state_d = ImemAck ? S_REQ : S_DRAIN;
        end else if (ImemAck) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (Redirect || InstrReady) state_d = S_REQ;
      end
      S_DRAIN: begin
        // A redirect keeps us draining; only a plain ack returns to REQ.
        if (!Redirect && ImemAck) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ImemReq  = (state_q == S_REQ) || (state_q == S_DRAIN);
    ImemAddr = (state_q == S_DRAIN) ? drain_q : pc_q;
  end

  // Datapath next values
  always_comb begin
    pc_d       = pc_q;
    drain_d    = drain_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;

    if (redir_act || fetch_done) pc_d = next_pc;

    if ((state_q == S_REQ) && Redirect && !ImemAck) drain_d = pc_q;

    if (fetch_done) begin
      instr_d    = ImemData;
      instr_pc_d = pc_q;
      valid_d    = 1'b1;
    end

    // Redirect squashes a held instruction even if decode is ready.
    if (redir_act || ((state_q == S_HOLD) && InstrReady)) valid_d = 1'b0;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      pc_q       <= RPC[AW-1:0];
      drain_q    <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      drain_q    <= drain_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  assign InstrValid = valid_q;
  assign Instr      = instr_q;
  assign InstrPC    = instr_pc_q;
  assign DbgState   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
import cpu_pkg::*;

module tb_fetch_unit;

  logic          clk;
  logic          rst_n;
  logic          redirect;
  logic [23:0]   redirect_pc;
  logic          imem_req;
  logic [23:0]   imem_addr;
  logic          imem_ack;
  logic [23:0]   imem_data;
  logic          instr_valid;
  logic          instr_ready;
  logic [23:0]   instr;
  logic [23:0]   instr_pc;
  fetch_state_t  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [23:0] exp_q[$];
  logic [23:0] exp_word;

  fetch_unit dut (
    .Clock      (clk),
    .Reset_n    (rst_n),
    .Redirect   (redirect),
    .RedirectPC (redirect_pc),
    .ImemReq    (imem_req),
    .ImemAddr   (imem_addr),
    .ImemAck    (imem_ack),
    .ImemData   (imem_data),
    .InstrValid (instr_valid),
    .InstrReady (instr_ready),
    .Instr      (instr),
    .InstrPC    (instr_pc),
    .DbgState   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an ack with data for exactly one edge.
  task automatic ack_once(input logic [23:0] data, input logic expect_kept);
    imem_ack  = 1'b1;
    imem_data = data;
    if (expect_kept) exp_q.push_back(data);
    step();
    imem_ack  = 1'b0;
    imem_data = '0;
  endtask

  task automatic check_instr(input string tag);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp_word = exp_q.pop_front();
      check(tag, instr, exp_word);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_ack    = 1'b0;
    imem_data   = '0;
    instr_ready = 1'b0;

    // Reset state
    step();
    check("rst_req",   imem_req,    0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr,       0);
    check("rst_ipc",   instr_pc,    0);
    check("rst_state", dbg_state,   S_IDLE);

    // 1: release, first fetch
    rst_n = 1'b1;
    step();
    check("t1_state", dbg_state, S_REQ);
    check("t1_req",   imem_req,  1);
    check("t1_addr",  imem_addr, 24'h000000);
    ack_once(24'h123456, 1'b1);
    check("t1_valid", instr_valid, 1);
    check_instr("t1_instr");
    check("t1_ipc",   instr_pc,    24'h000000);
    check("t1_req0",  imem_req,    0);

    // 2: decode stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_valid", instr_valid, 1);
      check("t2_instr", instr,       24'h123456);
      check("t2_ipc",   instr_pc,    24'h000000);
      check("t2_req",   imem_req,    0);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("t2_valid0", instr_valid, 0);
    check("t2_req1",   imem_req,    1);
    check("t2_addr",   imem_addr,   24'h000001);

    // 3: redirect while request pending
    redirect    = 1'b1;
    redirect_pc = 24'h00ABCD;
    step();
    redirect = 1'b0;
    check("t3_state", dbg_state, S_DRAIN);
    for (int i = 0; i < 3; i++) begin
      check("t3_req",   imem_req,    1);
      check("t3_addr",  imem_addr,   24'h000001);
      check("t3_valid", instr_valid, 0);
      if (i < 2) step();
    end
    ack_once(24'hDEAD01, 1'b0);
    check("t3_valid_d", instr_valid, 0);
    check("t3_req2",    imem_req,    1);
    check("t3_addr2",   imem_addr,   24'h00ABCD);
    ack_once(24'h0A0A0A, 1'b1);
    check("t3_valid2",  instr_valid, 1);
    check_instr("t3_instr");
    check("t3_ipc",     instr_pc,    24'h00ABCD);

    // 4: redirect with InstrReady in HOLD squashes
    redirect    = 1'b1;
    redirect_pc = 24'h000100;
    instr_ready = 1'b1;
    step();
    redirect    = 1'b0;
    instr_ready = 1'b0;
    check("t4_valid", instr_valid, 0);
    check("t4_state", dbg_state,   S_REQ);
    check("t4_addr",  imem_addr,   24'h000100);

    // 5: redirect to FFFFFF coinciding with an ack (data dropped), then wrap
    redirect    = 1'b1;
    redirect_pc = 24'hFFFFFF;
    ack_once(24'hBADBAD, 1'b0);
    redirect = 1'b0;
    check("t5_state", dbg_state,   S_REQ);
    check("t5_valid", instr_valid, 0);
    check("t5_addr",  imem_addr,   24'hFFFFFF);
    ack_once(24'h777777, 1'b1);
    check("t5_valid2", instr_valid, 1);
    check_instr("t5_instr");
    check("t5_ipc",    instr_pc,    24'hFFFFFF);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("t5_wrap",  imem_addr, 24'h000000);

    // 6: async reset mid-DRAIN
    redirect    = 1'b1;
    redirect_pc = 24'h000500;
    step();
    redirect = 1'b0;
    check("t6_state", dbg_state, S_DRAIN);
    check("t6_req",   imem_req,  1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rreq",   imem_req,    0);
    check("t6_rvalid", instr_valid, 0);
    check("t6_rinstr", instr,       0);
    check("t6_ripc",   instr_pc,    0);
    check("t6_raddr",  imem_addr,   24'h000000);
    check("t6_rstate", dbg_state,   S_IDLE);
    step();
    rst_n = 1'b1;
    // Redirect in IDLE must be ignored.
    redirect    = 1'b1;
    redirect_pc = 24'h000ABC;
    step();
    redirect = 1'b0;
    check("t6_state2", dbg_state, S_REQ);
    check("t6_addr2",  imem_addr, 24'h000000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
